// File: rtl/hack_mem_responder_if.sv
// CPU-side memory bus plus the screen handshake and board I/O of the Hack
// memory responder. The responder uses the slave modport; the CPU/board
// model drives the bus through the master modport.
interface hack_mem_responder_if;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        stall;
  logic        scr_req;
  logic        scr_we;
  logic [12:0] scr_addr;
  logic [15:0] scr_wdata;
  logic [15:0] scr_rdata;
  logic        scr_ack;
  logic [15:0] kbd_data;
  logic [15:0] led;
  logic        err;

  modport slave (
    input  addressM, outM, writeM, scr_rdata, scr_ack, kbd_data,
    output inM, stall, scr_req, scr_we, scr_addr, scr_wdata, led, err
  );

  modport master (
    output addressM, outM, writeM, scr_rdata, scr_ack, kbd_data,
    input  inM, stall, scr_req, scr_we, scr_addr, scr_wdata, led, err
  );
endinterface

// File: rtl/hack_mem_responder.sv
// Hack computer data-memory responder: 16K-word RAM with asynchronous read,
// a stalling request/ack bridge to an external screen memory with a
// timeout, a synchronized keyboard register and an LED register.
module hack_mem_responder #(
  parameter int SCR_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  hack_mem_responder_if.slave  bus
);

  localparam int CW = (SCR_TIMEOUT < 2) ? 1 : $clog2(SCR_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic            scr_req_q;
  logic            scr_we_q;
  logic [12:0]     scr_addr_q;
  logic [15:0]     scr_wdata_q;
  logic [15:0]     rd_hold_q;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     led_q;
  logic            err_q;
  logic [15:0]     kbd_s1_q;
  logic [15:0]     kbd_s2_q;

  logic [15:0]     mem [16384];

  logic            is_ram, is_scr, is_kbd, is_led;
  logic            stall;
  logic [15:0]     rdata_mux;

  // Address decode; keyboard and LED are single full-address matches so the
  // rest of the 0x6000 page stays unmapped.
  assign is_ram = (bus.addressM[14] == 1'b0);
  assign is_scr = (bus.addressM[14:13] == 2'b10);
  assign is_kbd = (bus.addressM == 15'h6000);
  assign is_led = (bus.addressM == 15'h6001);

  // The CPU is held from the first cycle it presents a screen address until
  // the transaction reaches DONE, where it picks up the read data.
  assign stall = ((state_q == S_IDLE) && is_scr) || (state_q == S_WAIT);

  // Read-data mux back to the CPU; screen data is only valid in DONE.
  always_comb begin
    rdata_mux = 16'h0000;
    if (is_ram)
      rdata_mux = mem[bus.addressM[13:0]];
    else if (is_scr) begin
      if (state_q == S_DONE) rdata_mux = rd_hold_q;
    end
    else if (is_kbd)
      rdata_mux = kbd_s2_q;
    else if (is_led)
      rdata_mux = led_q;
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.writeM && is_ram && !stall)
      mem[bus.addressM[13:0]] <= bus.outM;
  end

  // Two-flop synchronizer for the free-running keyboard code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kbd_s1_q <= 16'h0000;
      kbd_s2_q <= 16'h0000;
    end else begin
      kbd_s1_q <= bus.kbd_data;
      kbd_s2_q <= kbd_s1_q;
    end
  end

  // LED register, loaded by a CPU write to its address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      led_q <= 16'h0000;
    else if (bus.writeM && is_led)
      led_q <= bus.outM;
  end

  // Screen transaction FSM: capture request on IDLE->WAIT, hold it until ack
  // or timeout, then spend one DONE cycle handing data back. An ack in the
  // final timeout cycle wins over the timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      scr_req_q   <= 1'b0;
      scr_we_q    <= 1'b0;
      scr_addr_q  <= 13'h0000;
      scr_wdata_q <= 16'h0000;
      rd_hold_q   <= 16'h0000;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_scr) begin
            state_q     <= S_WAIT;
            scr_req_q   <= 1'b1;
            scr_we_q    <= bus.writeM;
            scr_addr_q  <= bus.addressM[12:0];
            scr_wdata_q <= bus.outM;
            cnt_q       <= '0;
          end
        end
        S_WAIT: begin
          if (bus.scr_ack) begin
            rd_hold_q <= bus.scr_rdata;
            scr_req_q <= 1'b0;
            state_q   <= S_DONE;
          end else if (cnt_q == CW'(SCR_TIMEOUT - 1)) begin
            err_q     <= 1'b1;
            rd_hold_q <= 16'h0000;
            scr_req_q <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          scr_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inM       = rdata_mux;
  assign bus.stall     = stall;
  assign bus.scr_req   = scr_req_q;
  assign bus.scr_we    = scr_we_q;
  assign bus.scr_addr  = scr_addr_q;
  assign bus.scr_wdata = scr_wdata_q;
  assign bus.led       = led_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_hack_mem_responder.sv
// Self-checking bench for hack_mem_responder: randomized traffic against a
// behavioural model (word-addressed RAM map, LED/err variables, and the
// cycle-cost rule of a screen access).
module tb_hack_mem_responder;
  localparam int T = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic        err_m = 1'b0;
  logic [15:0] led_m = 16'h0000;
  logic [15:0] ref_ram [int];

  hack_mem_responder_if bus();

  hack_mem_responder #(.SCR_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.addressM = 15'h0000; bus.outM = 16'h0000; bus.writeM = 1'b0;
    bus.scr_rdata = 16'h0000; bus.scr_ack = 1'b0; bus.kbd_data = 16'h0000;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.scr_req, bus.scr_we, bus.stall, bus.err} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl got %b exp 0000", {bus.scr_req, bus.scr_we, bus.stall, bus.err});
    end
    tests++;
    if ({bus.led, bus.scr_addr, bus.scr_wdata} !== 45'h0) begin
      fails++; $display("FAIL reset_regs got led=%h addr=%h wdata=%h exp 0", bus.led, bus.scr_addr, bus.scr_wdata);
    end
    bus.addressM = 15'h6000;
    #1;
    tests++;
    if (bus.inM !== 16'h0000) begin
      fails++; $display("FAIL reset_kbd got %h exp 0000", bus.inM);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ram;
    int q[$];
    bus.writeM = 1'b1; bus.addressM = 15'h0010; bus.outM = 16'h1234;
    @(negedge clk);
    tests++;
    if (bus.stall !== 1'b0) begin fails++; $display("FAIL ram_wr_stall got %b exp 0", bus.stall); end
    tick();
    ref_ram[16'h0010] = 16'h1234;
    bus.writeM = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.inM !== 16'h1234 || bus.stall !== 1'b0) begin
      fails++; $display("FAIL ram_rt_0010 got inM=%h stall=%b exp 1234/0", bus.inM, bus.stall);
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      int a;
      logic [15:0] d;
      a = $urandom_range(0, 16'h3FFF);
      d = 16'($urandom);
      bus.writeM = 1'b1; bus.addressM = 15'(a); bus.outM = d;
      @(negedge clk);
      tests++;
      if (bus.stall !== 1'b0) begin fails++; $display("FAIL ram_wr_stall got %b exp 0", bus.stall); end
      tick();
      ref_ram[a] = d;
      q.push_back(a);
    end
    bus.writeM = 1'b0;
    foreach (q[i]) begin
      bus.addressM = 15'(q[i]);
      #1;
      tests++;
      if (bus.inM !== ref_ram[q[i]]) begin
        fails++; $display("FAIL ram_read @%h got %h exp %h", q[i], bus.inM, ref_ram[q[i]]);
      end
    end
    tick();
  endtask

  // One screen transaction starting in IDLE. lat in 1..T: ack arrives in the
  // lat-th WAIT cycle; otherwise no ack and the access times out after T
  // WAIT cycles. Random acks are thrown at the IDLE and DONE cycles.
  task automatic do_screen(input logic [14:0] a, input logic we, input logic [15:0] wd,
                           input logic [15:0] rd, input int lat, input bit park);
    int   nw;
    bit   timed;
    logic err_before;
    timed = !(lat >= 1 && lat <= T);
    nw = timed ? T : lat;
    err_before = err_m;
    bus.addressM = a; bus.writeM = we; bus.outM = wd;
    bus.scr_ack = 1'($urandom_range(0, 1)); bus.scr_rdata = 16'($urandom);
    @(negedge clk);
    tests++;
    if (bus.stall !== 1'b1 || bus.scr_req !== 1'b0 || bus.inM !== 16'h0000) begin
      fails++; $display("FAIL scr_idle @%h got stall=%b req=%b inM=%h exp 1/0/0000", a, bus.stall, bus.scr_req, bus.inM);
    end
    tick();
    for (int i = 1; i <= nw; i++) begin
      bus.scr_ack = (i == lat);
      bus.scr_rdata = (i == lat) ? rd : 16'($urandom);
      @(negedge clk);
      tests++;
      if ({bus.scr_req, bus.scr_we, bus.scr_addr, bus.scr_wdata, bus.stall, bus.err, bus.inM} !==
          {1'b1, we, a[12:0], wd, 1'b1, err_before, 16'h0000}) begin
        fails++;
        $display("FAIL scr_wait @%h cyc%0d got req=%b we=%b addr=%h wd=%h stall=%b err=%b inM=%h exp 1/%b/%h/%h/1/%b/0000",
                 a, i, bus.scr_req, bus.scr_we, bus.scr_addr, bus.scr_wdata, bus.stall, bus.err, bus.inM,
                 we, a[12:0], wd, err_before);
      end
      tick();
    end
    if (timed) err_m = 1'b1;
    bus.scr_ack = 1'($urandom_range(0, 1)); bus.scr_rdata = 16'($urandom);
    @(negedge clk);
    tests++;
    if (bus.scr_req !== 1'b0 || bus.stall !== 1'b0 || bus.err !== err_m) begin
      fails++; $display("FAIL scr_done @%h got req=%b stall=%b err=%b exp 0/0/%b", a, bus.scr_req, bus.stall, bus.err, err_m);
    end
    if (!we) begin
      tests++;
      if (bus.inM !== (timed ? 16'h0000 : rd)) begin
        fails++; $display("FAIL scr_rdata @%h got %h exp %h", a, bus.inM, timed ? 16'h0000 : rd);
      end
    end
    tick();
    bus.scr_ack = 1'b0;
    if (park) begin
      bus.addressM = 15'h0000; bus.writeM = 1'b0;
      bus.scr_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests++;
      if (bus.stall !== 1'b0 || bus.scr_req !== 1'b0 || bus.err !== err_m) begin
        fails++; $display("FAIL scr_park got stall=%b req=%b err=%b exp 0/0/%b", bus.stall, bus.scr_req, bus.err, err_m);
      end
      tick();
      bus.scr_ack = 1'b0;
    end
  endtask

  task automatic test_screen_write;
    do_screen(15'h4005, 1'b1, 16'hBEEF, 16'h0000, 3, 1'b1);
  endtask

  task automatic test_screen_read;
    do_screen(15'h5FFF, 1'b0, 16'h0000, 16'h00FF, 2, 1'b1);
    do_screen(15'h4000, 1'b0, 16'h0000, 16'hA5C3, 1, 1'b1);
  endtask

  task automatic test_timeout;
    // ack coinciding with the last allowed cycle is a success, not an error
    do_screen(15'h4ABC, 1'b0, 16'h0000, 16'h7E57, T, 1'b1);
    do_screen(15'h4321, 1'b0, 16'h0000, 16'h1111, 0, 1'b1);
    do_screen(15'h5001, 1'b1, 16'h2222, 16'h0000, 2, 1'b1);
    do_screen(15'h5002, 1'b0, 16'h0000, 16'h3333, 1, 1'b1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      do_screen(15'h4000 | 15'($urandom_range(0, 16'h1FFF)), 1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom), $urandom_range(1, 4), (i == 5));
    end
  endtask

  task automatic test_kbd;
    logic [15:0] prev;
    logic [15:0] nxt;
    prev = 16'h0000;
    bus.addressM = 15'h6000; bus.writeM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt = (i == 0) ? 16'h0041 : 16'($urandom);
      bus.kbd_data = nxt;
      for (int e = 0; e < 3; e++) begin
        @(negedge clk);
        tests++;
        if (bus.inM !== ((e == 2) ? nxt : prev)) begin
          fails++; $display("FAIL kbd_sync val%0d edge%0d got %h exp %h", i, e, bus.inM, (e == 2) ? nxt : prev);
        end
        if (e < 2) tick();
      end
      tick();
      prev = nxt;
    end
    bus.writeM = 1'b1; bus.outM = ~prev;
    tick();
    bus.writeM = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.inM !== prev) begin fails++; $display("FAIL kbd_write_ignored got %h exp %h", bus.inM, prev); end
    tick();
  endtask

  task automatic test_led;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] d;
      d = (i == 0) ? 16'h00AA : 16'($urandom);
      bus.addressM = 15'h6001; bus.writeM = 1'b1; bus.outM = d;
      @(negedge clk);
      tests++;
      if (bus.led !== led_m) begin fails++; $display("FAIL led_before_edge got %h exp %h", bus.led, led_m); end
      tick();
      led_m = d;
      bus.writeM = 1'b0;
      #1;
      tests++;
      if (bus.led !== led_m || bus.inM !== led_m) begin
        fails++; $display("FAIL led_load got led=%h inM=%h exp %h", bus.led, bus.inM, led_m);
      end
    end
    tick();
  endtask

  task automatic test_unmapped;
    bus.addressM = 15'h3000; bus.writeM = 1'b1; bus.outM = 16'h5A5A;
    tick();
    ref_ram[16'h3000] = 16'h5A5A;
    for (int i = 0; i < 6; i++) begin
      bus.addressM = (i == 0) ? 15'h7000 : 15'($urandom_range(16'h6002, 16'h7FFF));
      bus.writeM = 1'b1; bus.outM = 16'($urandom);
      #1;
      tests++;
      if (bus.inM !== 16'h0000 || bus.stall !== 1'b0) begin
        fails++; $display("FAIL unmapped_read @%h got inM=%h stall=%b exp 0000/0", bus.addressM, bus.inM, bus.stall);
      end
      tick();
    end
    bus.writeM = 1'b0; bus.addressM = 15'h3000;
    #1;
    tests++;
    if (bus.inM !== ref_ram[16'h3000] || bus.led !== led_m || bus.err !== err_m) begin
      fails++; $display("FAIL unmapped_write_effect got ram=%h led=%h err=%b exp %h/%h/%b",
                        bus.inM, bus.led, bus.err, ref_ram[16'h3000], led_m, err_m);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait;
    bus.addressM = 15'h0100; bus.writeM = 1'b1; bus.outM = 16'hCAFE;
    tick();
    ref_ram[16'h0100] = 16'hCAFE;
    bus.addressM = 15'h4100; bus.writeM = 1'b0;
    tick();
    tick();
    tests++;
    if (bus.scr_req !== 1'b1) begin fails++; $display("FAIL rstmid_in_wait got req=%b exp 1", bus.scr_req); end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (bus.scr_req !== 1'b0 || bus.led !== 16'h0000 || bus.err !== 1'b0 || bus.stall !== 1'b1) begin
      fails++; $display("FAIL rstmid_assert got req=%b led=%h err=%b stall=%b exp 0/0000/0/1",
                        bus.scr_req, bus.led, bus.err, bus.stall);
    end
    bus.addressM = 15'h0100;
    #1;
    tests++;
    if (bus.stall !== 1'b0 || bus.inM !== ref_ram[16'h0100]) begin
      fails++; $display("FAIL rstmid_ram got stall=%b inM=%h exp 0/%h", bus.stall, bus.inM, ref_ram[16'h0100]);
    end
    @(negedge clk);
    rst = 1'b1;
    err_m = 1'b0; led_m = 16'h0000;
    tick();
    @(negedge clk);
    tests++;
    if (bus.scr_req !== 1'b0 || bus.stall !== 1'b0 || bus.inM !== 16'hCAFE) begin
      fails++; $display("FAIL rstmid_after got req=%b stall=%b inM=%h exp 0/0/cafe", bus.scr_req, bus.stall, bus.inM);
    end
    tick();
    do_screen(15'h4777, 1'b0, 16'h0000, 16'h0BAD, 2, 1'b1);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_screen_write();
    test_screen_read();
    test_timeout();
    test_back_to_back();
    test_kbd();
    test_led();
    test_unmapped();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hack_mem_responder.md
HACK_MEM_RESPONDER -- requirements
Module: hack_mem_responder

Interface
REQ-001 The module SHALL have parameter SCR_TIMEOUT, default 255, which is the maximum number of cycles to wait for scr_ack before aborting.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port addressM, input, 15 bits: CPU data address.
REQ-005 The module SHALL have port outM, input, 16 bits: CPU write data.
REQ-006 The module SHALL have port writeM, input, 1 bit: CPU write strobe.
REQ-007 The module SHALL have port inM, output, 16 bits: read data returned to the CPU (combinational).
REQ-008 The module SHALL have port stall, output, 1 bit: CPU hold request while a screen access is pending.
REQ-009 The module SHALL have port scr_req, output, 1 bit: screen request.
REQ-010 The module SHALL have port scr_we, output, 1 bit: screen write enable.
REQ-011 The module SHALL have port scr_addr, output, 13 bits: screen word address.
REQ-012 The module SHALL have port scr_wdata, output, 16 bits: screen write data.
REQ-013 The module SHALL have port scr_rdata, input, 16 bits: screen read data.
REQ-014 The module SHALL have port scr_ack, input, 1 bit: screen acknowledge.
REQ-015 The module SHALL have port kbd_data, input, 16 bits: asynchronous keyboard code.
REQ-016 The module SHALL have port led, output, 16 bits: LED register.
REQ-017 The module SHALL have port err, output, 1 bit: sticky screen-timeout flag.

Function
REQ-018 Address decode SHALL be as follows: 0x0000-0x3FFF RAM; 0x4000-0x5FFF screen; 0x6000 keyboard; 0x6001 LED; 0x6002-0x7FFF unmapped.
REQ-019 The RAM SHALL be 16384x16 with an asynchronous read, so that inM = ram[addressM] in the same cycle.
REQ-020 A RAM write SHALL occur on the rising edge when writeM=1, the address is in the RAM region, and stall=0.
REQ-021 The keyboard input SHALL pass through a 2-flop synchronizer per bit; a read of 0x6000 SHALL return the synchronized value, and writes to 0x6000 SHALL be ignored.
REQ-022 A write to 0x6001 SHALL load led from outM on the clock edge; a read of 0x6001 SHALL return led.
REQ-023 Unmapped reads SHALL return 0x0000; unmapped writes SHALL have no effect.
REQ-024 The screen FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-025 In IDLE, when the address is in the screen region, the FSM SHALL go to WAIT.
REQ-026 On entering WAIT, the FSM SHALL register scr_addr=addressM[12:0], scr_we=writeM, and scr_wdata=outM, and SHALL clear the timeout counter.
REQ-027 In WAIT, the FSM SHALL hold scr_req=1 with the request fields stable until scr_ack=1.
REQ-028 In WAIT, on scr_ack=1 the FSM SHALL latch scr_rdata into rd_hold, drop scr_req, and go to DONE.
REQ-029 In WAIT, when the counter reaches SCR_TIMEOUT without an acknowledge, the FSM SHALL set err=1, load rd_hold=0x0000, drop scr_req, and go to DONE.
REQ-030 In DONE, the FSM SHALL return to IDLE unconditionally after one cycle.
REQ-031 stall SHALL be 1 combinationally whenever (IDLE and a screen address) or WAIT; stall SHALL be 0 in DONE.
REQ-032 A screen read SHALL present inM=rd_hold only in DONE; a screen-region inM SHALL be 0x0000 in any other state.
REQ-033 A screen access SHALL cost 2 + ack-latency cycles; back-to-back screen accesses SHALL each start a fresh transaction from IDLE.
REQ-034 An scr_ack arriving in the same cycle as the timeout SHALL count as an acknowledge, with no err.
REQ-035 An scr_ack that is asserted while the FSM is in IDLE or DONE SHALL be ignored.
REQ-036 err SHALL be sticky and SHALL clear only on reset.

Reset
REQ-037 With rst=0, the module SHALL asynchronously force: FSM=IDLE, scr_req=0, scr_we=0, scr_addr=0, scr_wdata=0, rd_hold=0, timeout counter=0, led=0x0000, err=0, synchronizer flops=0.
REQ-038 RAM contents SHALL NOT be reset.
REQ-039 A reset asserted mid-transaction SHALL abandon the transaction immediately, with scr_req=0 on assertion.
REQ-040 Operation SHALL begin on the first rising edge after rst deasserts.

Verification
REQ-041 The bench SHALL cover a RAM round-trip: write 0x1234 @0x0010, then read 0x0010 -> inM=0x1234 in the same cycle, stall=0 throughout.
REQ-042 The bench SHALL cover a screen write with ack after 3 cycles: write 0xBEEF @0x4005 -> scr_req=1, scr_we=1, scr_addr=0x0005, scr_wdata=0xBEEF, held for 3 cycles; stall high through WAIT; one DONE cycle with stall=0.
REQ-043 The bench SHALL cover a screen read: read 0x5FFF with scr_rdata=0x00FF acked -> scr_addr=0x1FFF, inM=0x00FF in DONE, 0x0000 otherwise.
REQ-044 The bench SHALL cover a timeout: screen read with no ack -> after SCR_TIMEOUT cycles err=1, inM=0x0000 in DONE, err still 1 after further traffic.
REQ-045 The bench SHALL cover the keyboard, LED, and unmapped locations: kbd_data=0x0041 -> read 0x6000 returns 0x0041 no earlier than 2 edges later; write 0x00AA @0x6001 -> led=0x00AA; read 0x7000 -> 0x0000.
REQ-046 The bench SHALL cover reset mid-WAIT: rst=0 -> scr_req, stall, and led immediately 0 (stall 0 unless the address is in the screen region); a RAM word written before reset SHALL be unchanged.
